// File: rtl/pre_track_result_sched_if.sv
// Handshake/bus bundle for the previous-track result scheduler; slave is the scheduler side.
interface pre_track_result_sched_if;
    logic        laser_start;
    logic        second_track_en;
    logic        laser_vld;
    logic        pre_laser_rd_ready;
    logic        pre_laser_rd_seq;
    logic        pre_laser_rd_vld;
    logic [63:0] pre_laser_rd_data;
    logic        pre_track_result;
    logic        pre_track_result_vld;
    logic        prefetch_done;
    logic [31:0] underflow_cnt;
    logic        rd_err;
    logic [1:0]  state;

    modport slave (
        input  laser_start, second_track_en, laser_vld,
        input  pre_laser_rd_ready, pre_laser_rd_vld, pre_laser_rd_data,
        output pre_laser_rd_seq, pre_track_result, pre_track_result_vld,
        output prefetch_done, underflow_cnt, rd_err, state
    );

    modport master (
        output laser_start, second_track_en, laser_vld,
        output pre_laser_rd_ready, pre_laser_rd_vld, pre_laser_rd_data,
        input  pre_laser_rd_seq, pre_track_result, pre_track_result_vld,
        input  prefetch_done, underflow_cnt, rd_err, state
    );
endinterface

// File: rtl/pre_track_result_sched.sv
// Prefetches 64-bit previous-track result words from DDR and serialises one bit per laser_vld; result is 1 cycle late.
// Reads issue only while rd_ready is high and buffer credits remain; an empty buffer yields 0 and counts underflow.
module pre_track_result_sched #(
    parameter int FIFO_DEPTH     = 8,
    parameter int PREFETCH_WORDS = 4
) (
    input logic clk,
    input logic rst,
    pre_track_result_sched_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PREFETCH = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    state_t        state_q;
    logic          start_d;
    logic          pend;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outst, outst_nxt;
    logic [5:0]    bit_idx;
    logic [31:0]   underflow_q;
    logic          result_q, result_vld_q, rd_err_q;

    logic start_rise, start_fall, active, credit, req, ret_ok, full;
    logic push, pop, consume, hit, err_set, pend_nxt, flush, prefetch_met;

    always_comb begin
        start_rise   = bus.laser_start & ~start_d;
        start_fall   = ~bus.laser_start & start_d;
        active       = (state_q == PREFETCH) || (state_q == RUN);
        credit       = ({1'b0, outst} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
        req          = active & bus.pre_laser_rd_ready & credit;
        ret_ok       = bus.pre_laser_rd_vld & (outst != '0);
        full         = (count == CW'(FIFO_DEPTH));
        push         = ret_ok & active & ~full;
        err_set      = bus.pre_laser_rd_vld & ((outst == '0) | (active & full));
        consume      = bus.laser_vld & (state_q == RUN);
        hit          = consume & (count != '0);
        pop          = hit & (bit_idx == 6'd63);
        outst_nxt    = outst + CW'(req) - CW'(ret_ok);
        pend_nxt     = pend | (start_rise & bus.second_track_en);
        prefetch_met = ({1'b0, count} + (CW+1)'(push)) >= (CW+1)'(PREFETCH_WORDS);
        // A new track restarts from an empty buffer, both from IDLE and on a deferred restart out of DRAIN.
        flush        = ((state_q == IDLE) & start_rise & bus.second_track_en) |
                       ((state_q == DRAIN) & (outst_nxt == '0) & pend_nxt);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.pre_laser_rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_d      <= 1'b0;
            pend         <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            outst        <= '0;
            bit_idx      <= '0;
            underflow_q  <= '0;
            result_q     <= 1'b0;
            result_vld_q <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            start_d      <= bus.laser_start;
            outst        <= outst_nxt;
            rd_err_q     <= rd_err_q | err_set;
            result_vld_q <= bus.laser_vld & bus.laser_start;
            result_q     <= hit & mem[rd_ptr][bit_idx];

            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                bit_idx     <= '0;
                underflow_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                if (hit) bit_idx <= bit_idx + 6'd1;
                if (consume && count == '0 && underflow_q != '1)
                    underflow_q <= underflow_q + 32'd1;
            end

            pend <= 1'b0;
            case (state_q)
                IDLE:     if (flush) state_q <= PREFETCH;
                PREFETCH: begin
                    if (start_fall)        state_q <= DRAIN;
                    else if (prefetch_met) state_q <= RUN;
                end
                RUN:      if (start_fall) state_q <= DRAIN;
                DRAIN: begin
                    if (outst_nxt == '0) state_q <= pend_nxt ? PREFETCH : IDLE;
                    else                 pend    <= pend_nxt;
                end
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign bus.pre_laser_rd_seq     = req;
    assign bus.pre_track_result     = result_q;
    assign bus.pre_track_result_vld = result_vld_q;
    assign bus.prefetch_done        = (state_q == RUN);
    assign bus.underflow_cnt        = underflow_q;
    assign bus.rd_err               = rd_err_q;
    assign bus.state                = state_q;
endmodule

// File: tb/tb_pre_track_result_sched.sv
// Directed bench: DDR model with 5-cycle read latency, hand-computed expectations per scenario.
module tb_pre_track_result_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pre_track_result_sched_if ifc();

    pre_track_result_sched #(.FIFO_DEPTH(8), .PREFETCH_WORDS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    localparam int LAT = 5;

    int          cyc = 0, seq_cnt = 0, ret_idx = 0;
    int          n_chk = 0, n_pass = 0;
    int          done_rise_cyc = -1, last_vld_cyc = -1;
    int          ret_q[$];
    int          vld_hist[$];
    logic        res_q[$];
    bit          spur = 1'b0;
    logic        done_prev = 1'b0;
    logic [63:0] words [0:63];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // One clock: sample the request mid-cycle, then after the edge record outputs and drive returns.
    task automatic cycle();
        @(negedge clk);
        if (ifc.pre_laser_rd_seq === 1'b1) begin
            seq_cnt++;
            ret_q.push_back(cyc + LAT);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ifc.pre_track_result_vld === 1'b1) res_q.push_back(ifc.pre_track_result);
        if (ifc.prefetch_done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = ifc.prefetch_done;
        ifc.pre_laser_rd_vld = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            void'(ret_q.pop_front());
            ifc.pre_laser_rd_vld  = 1'b1;
            ifc.pre_laser_rd_data = words[ret_idx % 64];
            ret_idx++;
            vld_hist.push_back(cyc);
            last_vld_cyc = cyc;
        end else if (spur) begin
            ifc.pre_laser_rd_vld  = 1'b1;
            ifc.pre_laser_rd_data = '0;
            spur = 1'b0;
        end
    endtask

    function automatic logic [63:0] pack_word(input int base);
        logic [63:0] w;
        for (int i = 0; i < 64; i++)
            w[i] = (base + i < res_q.size()) ? res_q[base + i] : 1'bx;
        return w;
    endfunction

    initial begin
        int s0, base_word, ones;

        for (int i = 0; i < 64; i++)
            words[i] = 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
        words[0] = 64'h0000_0000_0000_0005;
        words[1] = 64'h0000_0000_0000_0002;

        ifc.laser_start = 0; ifc.second_track_en = 0; ifc.laser_vld = 0;
        ifc.pre_laser_rd_ready = 0; ifc.pre_laser_rd_vld = 0; ifc.pre_laser_rd_data = '0;
        rst = 1'b1;
        repeat (3) cycle();
        check_eq("rst_state", ifc.state, 0);
        check_eq("rst_seq", ifc.pre_laser_rd_seq, 0);
        check_eq("rst_res_vld", ifc.pre_track_result_vld, 0);
        check_eq("rst_done", ifc.prefetch_done, 0);
        check_eq("rst_uf", ifc.underflow_cnt, 0);
        check_eq("rst_err", ifc.rd_err, 0);
        rst = 1'b0;
        cycle();

        // Prefetch: eight credits, RUN the cycle after the 4th return
        ifc.second_track_en = 1; ifc.pre_laser_rd_ready = 1; ifc.laser_start = 1;
        vld_hist.delete();
        repeat (20) cycle();
        check_eq("pf_seq_cnt", seq_cnt, 8);
        check_eq("pf_returns", vld_hist.size(), 8);
        check_eq("pf_done_cycle", done_rise_cyc, (vld_hist.size() >= 4) ? vld_hist[3] + 1 : -2);
        check_eq("pf_state_run", ifc.state, 2);

        // Bit order over 66 samples and the single refill after the head pops
        res_q.delete();
        ifc.laser_vld = 1;
        repeat (66) cycle();
        ifc.laser_vld = 0;
        repeat (10) cycle();
        check_eq("bit_count", res_q.size(), 66);
        check_eq("bit_w0", pack_word(0), words[0]);
        check_eq("bit_w1_b0", (res_q.size() > 64) ? res_q[64] : 1'bx, 1'b0);
        check_eq("bit_w1_b1", (res_q.size() > 65) ? res_q[65] : 1'bx, 1'b1);
        check_eq("refill_seq", seq_cnt, 9);
        ifc.laser_start = 0;
        repeat (5) cycle();
        check_eq("t1_idle", ifc.state, 0);

        // Underflow: 4 words only, 300 samples
        base_word = ret_idx;
        s0 = seq_cnt;
        ifc.pre_laser_rd_ready = 1; ifc.laser_start = 1;
        for (int i = 0; i < 20 && seq_cnt - s0 < 4; i++) cycle();
        ifc.pre_laser_rd_ready = 0;
        for (int i = 0; i < 30 && ifc.state != 2; i++) cycle();
        check_eq("uf_state_run", ifc.state, 2);
        res_q.delete();
        ifc.laser_vld = 1;
        repeat (300) cycle();
        ifc.laser_vld = 0;
        cycle();
        check_eq("uf_count", res_q.size(), 300);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("uf_word%0d", k), pack_word(64 * k), words[base_word + k]);
        ones = 0;
        for (int i = 256; i < res_q.size(); i++) ones += int'(res_q[i]);
        check_eq("uf_tail_zero", ones, 0);
        check_eq("uf_cnt", ifc.underflow_cnt, 44);
        check_eq("uf_no_seq", seq_cnt - s0, 4);

        // Restart during DRAIN with two reads outstanding
        s0 = seq_cnt;
        ifc.pre_laser_rd_ready = 1;
        cycle(); cycle();
        ifc.pre_laser_rd_ready = 0;
        check_eq("rs_two_seq", seq_cnt - s0, 2);
        vld_hist.delete();
        ifc.laser_start = 0;
        cycle();
        ifc.laser_start = 1;
        cycle();
        check_eq("rs_drain", ifc.state, 3);
        check_eq("rs_uf_kept", ifc.underflow_cnt, 44);
        for (int i = 0; i < 30 && ifc.state == 3; i++) cycle();
        check_eq("rs_prefetch", ifc.state, 1);
        check_eq("rs_uf_clr", ifc.underflow_cnt, 0);
        check_eq("rs_both_ret", vld_hist.size(), 2);
        check_eq("rs_no_err", ifc.rd_err, 0);
        s0 = seq_cnt;
        ifc.pre_laser_rd_ready = 1;
        repeat (20) cycle();
        check_eq("rs_fifo_flushed", seq_cnt - s0, 8);
        check_eq("rs_run", ifc.state, 2);
        ifc.laser_start = 0;
        repeat (5) cycle();
        check_eq("rs_idle", ifc.state, 0);

        // Track end with three reads outstanding
        s0 = seq_cnt;
        vld_hist.delete();
        ifc.pre_laser_rd_ready = 1; ifc.laser_start = 1;
        for (int i = 0; i < 20 && seq_cnt - s0 < 3; i++) cycle();
        ifc.pre_laser_rd_ready = 0; ifc.laser_start = 0;
        cycle();
        check_eq("te_drain", ifc.state, 3);
        ifc.pre_laser_rd_ready = 1;
        for (int i = 0; i < 30 && ifc.state != 0; i++) cycle();
        check_eq("te_idle", ifc.state, 0);
        check_eq("te_no_seq", seq_cnt - s0, 3);
        check_eq("te_discarded", vld_hist.size(), 3);
        check_eq("te_idle_cycle", cyc, last_vld_cyc + 1);
        check_eq("te_no_err", ifc.rd_err, 0);
        ifc.pre_laser_rd_ready = 0;

        // Disabled second track
        s0 = seq_cnt;
        ifc.second_track_en = 0; ifc.pre_laser_rd_ready = 1; ifc.laser_start = 1;
        res_q.delete();
        ifc.laser_vld = 1;
        repeat (10) cycle();
        ifc.laser_vld = 0;
        cycle();
        check_eq("dis_no_seq", seq_cnt - s0, 0);
        check_eq("dis_state", ifc.state, 0);
        check_eq("dis_res_cnt", res_q.size(), 10);
        ones = 0;
        foreach (res_q[i]) ones += int'(res_q[i]);
        check_eq("dis_res_zero", ones, 0);
        ifc.laser_start = 0; ifc.pre_laser_rd_ready = 0;
        cycle();

        // Spurious return in IDLE, then reset clears the sticky flag
        check_eq("sp_err_before", ifc.rd_err, 0);
        spur = 1'b1;
        cycle(); cycle();
        check_eq("sp_err_set", ifc.rd_err, 1);
        rst = 1'b1;
        #1;
        check_eq("rst2_err", ifc.rd_err, 0);
        check_eq("rst2_state", ifc.state, 0);
        rst = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
